dma_egress_packetizer: RTL and testbench

Downstream of the DMA controller. Consumes the DMA sample stream (12-bit samples, valid, last), buffers it in a small FIFO, and emits framed 16-bit packets on a ready/valid egress stream toward the chiplet link. Each packet is one header word followed by sign-extended payload words. The header carries the active config mode and a rolling sequence number.

---
 rtl/dsp_egress_pkg.sv | 26 ++
 rtl/egress_sync_fifo.sv | 44 ++++
 rtl/dma_egress_packetizer.sv | 178 +++++++++++++++++
 tb/tb_dma_egress_packetizer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_egress_pkg.sv
// Shared types for the DMA egress packetizer: header layout, FSM states, sample sign-extension.
// The optional trailer checksum is enabled by defining EGRESS_CHECKSUM_EN.
package dsp_egress_pkg;

  localparam logic [3:0] HDR_MAGIC  = 4'hA;
  localparam int         HDR_RSVD_W = 3;
  localparam int         HDR_MODE_W = 5;
  localparam int         HDR_SEQ_W  = 4;

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, CSUM} egress_state_e;

  typedef struct packed {
    logic [3:0]            magic;
    logic [HDR_RSVD_W-1:0] rsvd;
    logic [HDR_MODE_W-1:0] mode;
    logic [HDR_SEQ_W-1:0]  seq;
  } egress_hdr_t;

  // Replicates bit w-1 of v into every bit above it; callers truncate to their word width.
  function automatic logic [31:0] sign_extend(input logic [31:0] v, input int w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = (i < w) ? v[i] : v[w-1];
    return r;
  endfunction

endpackage

// File: rtl/egress_sync_fifo.sv
// Single-clock FIFO with full/empty flags; a push is accepted while full if a pop happens
// in the same cycle.
module egress_sync_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/dma_egress_packetizer.sv
// Frames the DMA sample stream into header + sign-extended payload packets on a ready/valid
// egress port. Define EGRESS_CHECKSUM_EN to append a 16-bit wrapping-sum trailer word.
module dma_egress_packetizer
  import dsp_egress_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int BLOCK_SIZE = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic [4:0]            config_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  overflow,
  output logic [7:0]            pkt_count
);

  localparam int EW    = DATA_WIDTH + 1;
  localparam int CNT_W = $clog2(BLOCK_SIZE + 1);

  egress_state_e         state, state_nxt;
  logic [EW-1:0]         fifo_rdata;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  pop_last, pop_is_eop;
  logic [CNT_W-1:0]      pay_cnt;
  logic [HDR_SEQ_W-1:0]  seq;
  logic                  last_loaded;
  logic                  xfer;
  logic                  load_hdr, load_pay, end_pkt, drop_valid;
  egress_hdr_t           hdr;
`ifdef EGRESS_CHECKSUM_EN
  logic [15:0]           csum;
  logic                  load_trl;
`endif

  egress_sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .wdata ({in_last, in_data}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {pop_last, pop_data} = fifo_rdata;
  assign xfer       = out_valid && out_ready;
  assign fifo_pop   = load_pay;
  assign pop_is_eop = pop_last || (pay_cnt == CNT_W'(BLOCK_SIZE - 1));
  assign hdr        = '{magic: HDR_MAGIC, rsvd: '0, mode: config_mode, seq: seq};

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // last_loaded marks that the output register holds the packet's final payload word,
  // so no further entries are popped until it has transferred.
  always_comb begin
    state_nxt  = state;
    load_hdr   = 1'b0;
    load_pay   = 1'b0;
    end_pkt    = 1'b0;
    drop_valid = 1'b0;
`ifdef EGRESS_CHECKSUM_EN
    load_trl   = 1'b0;
`endif
    case (state)
      IDLE: if (!fifo_empty) begin
        load_hdr  = 1'b1;
        state_nxt = HDR;
      end
      HDR: if (out_ready) begin
        state_nxt  = PAYLOAD;
        load_pay   = !fifo_empty;
        drop_valid = fifo_empty;
      end
      PAYLOAD: begin
        if (xfer && last_loaded) begin
`ifdef EGRESS_CHECKSUM_EN
          load_trl   = 1'b1;
          state_nxt  = CSUM;
`else
          end_pkt    = 1'b1;
          drop_valid = 1'b1;
          state_nxt  = IDLE;
`endif
        end else if ((!out_valid || out_ready) && !last_loaded && !fifo_empty) begin
          load_pay = 1'b1;
        end else if (xfer) begin
          drop_valid = 1'b1;
        end
      end
`ifdef EGRESS_CHECKSUM_EN
      CSUM: if (out_ready) begin
        end_pkt    = 1'b1;
        drop_valid = 1'b1;
        state_nxt  = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      overflow    <= 1'b0;
      pkt_count   <= '0;
      seq         <= '0;
      pay_cnt     <= '0;
      last_loaded <= 1'b0;
`ifdef EGRESS_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      if (load_hdr) begin
        out_valid   <= 1'b1;
        out_sop     <= 1'b1;
        out_eop     <= 1'b0;
        out_data    <= OUT_WIDTH'(hdr);
        pay_cnt     <= '0;
        last_loaded <= 1'b0;
      end else if (load_pay) begin
        out_valid   <= 1'b1;
        out_sop     <= 1'b0;
        out_data    <= OUT_WIDTH'(sign_extend(32'(pop_data), DATA_WIDTH));
        pay_cnt     <= pay_cnt + CNT_W'(1);
        last_loaded <= pop_is_eop;
`ifdef EGRESS_CHECKSUM_EN
        out_eop     <= 1'b0;
`else
        out_eop     <= pop_is_eop;
`endif
`ifdef EGRESS_CHECKSUM_EN
      end else if (load_trl) begin
        // Trailer must include the payload word transferring this very cycle.
        out_data    <= OUT_WIDTH'(csum + out_data[15:0]);
        out_eop     <= 1'b1;
        last_loaded <= 1'b0;
`endif
      end else if (drop_valid) begin
        out_valid <= 1'b0;
        out_sop   <= 1'b0;
        out_eop   <= 1'b0;
      end

`ifdef EGRESS_CHECKSUM_EN
      if (load_hdr)
        csum <= '0;
      else if (xfer && state == PAYLOAD)
        csum <= csum + out_data[15:0];
`endif

      if (end_pkt) begin
        seq         <= seq + HDR_SEQ_W'(1);
        pkt_count   <= pkt_count + 8'd1;
        last_loaded <= 1'b0;
      end

      if (in_valid && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_egress_packetizer.sv
// Directed + randomized bench for dma_egress_packetizer against a packet-level scoreboard.
module tb_dma_egress_packetizer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [4:0]  config_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_sop, out_eop, overflow;
  logic [7:0]  pkt_count;

  dma_egress_packetizer dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .config_mode (config_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .overflow    (overflow),
    .pkt_count   (pkt_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected egress words {sop, eop, data} in transfer order.
  logic [17:0] exp_q[$];
  bit          m_open = 1'b0;
  int          m_cnt = 0;
  logic [3:0]  m_seq = '0;
  logic [7:0]  m_pkts = '0;
  logic [15:0] m_sum = '0;

  bit mon_en = 1'b1;
  bit gap_en = 1'b0;
  int cyc = 0;
  int eop_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Packet rules: header opens a packet, payload is sign-extended, last or 256th word ends it.
  task automatic model_accept(input logic [11:0] d, input bit last);
    logic [15:0] w;
    bit e;
    if (!m_open) begin
      exp_q.push_back({1'b1, 1'b0, 4'hA, 3'b000, config_mode, m_seq});
      m_open = 1'b1;
      m_cnt  = 0;
      m_sum  = '0;
    end
    w = {{4{d[11]}}, d};
    m_cnt++;
    m_sum = m_sum + w;
    e = last || (m_cnt == 256);
`ifdef EGRESS_CHECKSUM_EN
    exp_q.push_back({1'b0, 1'b0, w});
    if (e) exp_q.push_back({1'b0, 1'b1, m_sum});
`else
    exp_q.push_back({1'b0, e, w});
`endif
    if (e) begin
      m_open = 1'b0;
      m_seq  = m_seq + 4'd1;
      m_pkts = m_pkts + 8'd1;
    end
  endtask

  task automatic send(input logic [11:0] d, input bit last, input bit acc);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    if (acc) model_accept(d, last);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_valid_low"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  // Scoreboard and AXI-stream hold checker.
  initial begin
    logic [17:0] cur, prev, e;
    bit stall;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      cur = {out_sop, out_eop, out_data};
      if (!mon_en || !reset) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_word", 32'(cur), 32'(prev));
        end
        if (out_valid && out_ready) begin
          chk("word_available", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("egress_word", 32'(cur), 32'(e));
          end
          if (gap_en && out_sop && eop_cyc > 0) chk("eop_sop_gap", 32'(cyc - eop_cyc), 32'd2);
          if (gap_en && out_eop) eop_cyc = cyc;
        end
        stall = out_valid && !out_ready;
        prev  = cur;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sop", 32'(out_sop), 32'd0);
    chk("rst_out_eop", 32'(out_eop), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    @(posedge clk); #1;

    // Test 1: basic packet and header/payload latency.
    config_mode = 5'h03;
    out_ready = 1'b1;
    send(12'h001, 1'b0, 1'b1);
    chk("t1_no_hdr_yet", 32'(out_valid), 32'd0);
    send(12'h7FF, 1'b0, 1'b1);
    chk("t1_hdr_valid", 32'(out_valid), 32'd1);
    chk("t1_hdr_word", 32'({out_sop, out_data}), 32'h1A030);
    send(12'h800, 1'b0, 1'b1);
    chk("t1_first_payload", 32'({out_valid, out_sop, out_data}), 32'h20001);
    send(12'hFFF, 1'b1, 1'b1);
    drain("t1");
    chk("t1_pkt_count", 32'(pkt_count), 32'(m_pkts));

    // Test 2: sink stall holding the second payload word.
    send(12'h001, 1'b0, 1'b1);
    send(12'h7FF, 1'b0, 1'b1);
    send(12'h800, 1'b0, 1'b1);
    chk("t2_first_payload", 32'({out_valid, out_data}), 32'h10001);
    send(12'hFFF, 1'b1, 1'b1);
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t2_stall_word", 32'({out_valid, out_data}), 32'h107FF);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("t2");
    chk("t2_pkt_count", 32'(pkt_count), 32'(m_pkts));

    // Test 3: FIFO overflow with the sink blocked.
    config_mode = 5'h1F;
    out_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      send(12'(i * 37), 1'b0, i <= 16);
      if (i == 16) chk("t3_no_overflow_16", 32'(overflow), 32'd0);
      if (i == 17) chk("t3_overflow_17", 32'(overflow), 32'd1);
    end
    out_ready = 1'b1;
    drain("t3");
    chk("t3_overflow_sticky", 32'(overflow), 32'd1);
    send(12'h0AB, 1'b1, 1'b1);
    drain("t3_close");
    chk("t3_pkt_count", 32'(pkt_count), 32'(m_pkts));

    // Test 5: reset mid-packet after header plus two payload words.
    config_mode = 5'h0C;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(12'(100 + i), 1'b0, 1'b1);
    out_ready = 1'b1;
    n = 0;
    k = 0;
    while (n < 3 && k < 100) begin
      @(negedge clk);
      if (out_valid && out_ready) n++;
      k++;
    end
    chk("t5_handshakes", 32'(n), 32'd3);
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t5_valid_after_rst", 32'(out_valid), 32'd0);
    chk("t5_pkt_count_after_rst", 32'(pkt_count), 32'd0);
    chk("t5_overflow_after_rst", 32'(overflow), 32'd0);
    exp_q.delete();
    m_open = 1'b0;
    m_seq  = '0;
    m_pkts = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    send(12'h123, 1'b1, 1'b1);
    drain("t5");
    chk("t5_pkt_count", 32'(pkt_count), 32'(m_pkts));

    // Test 4: forced end of packet at 256 words.
    config_mode = 5'h15;
    for (int i = 1; i <= 300; i++) send(12'(i * 13), i == 300, 1'b1);
    drain("t4");
    chk("t4_pkt_count", 32'(pkt_count), 32'(m_pkts));

    // Test 6: single-sample packets, sequence wrap and one-cycle bubble.
    config_mode = 5'h09;
    eop_cyc = 0;
    gap_en  = 1'b1;
    for (int i = 0; i < 17; i++) send(12'(i + 1), 1'b1, 1'b1);
    drain("t6");
    gap_en = 1'b0;
    chk("t6_pkt_count", 32'(pkt_count), 32'(m_pkts));

    // Randomized traffic with random backpressure; occupancy kept below FIFO depth.
    config_mode = 5'($urandom_range(0, 31));
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (exp_q.size() < 12 && $urandom_range(0, 1) == 1)
        send(12'($urandom_range(0, 4095)), $urandom_range(0, 15) == 0, 1'b1);
      else begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    if (m_open) send(12'h5A5, 1'b1, 1'b1);
    drain("rand");
    chk("rand_pkt_count", 32'(pkt_count), 32'(m_pkts));
    chk("rand_no_overflow", 32'(overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
